// File: rtl/tdm_mux_8to1.sv
`default_nettype none
// tdm_mux_8to1: serialises an 8-bit parallel frame onto one TDM line, one channel per cycle.
// Optional macro TDM_PARITY_EN appends an even-parity slot and adds the parity_slot output.
module tdm_mux_8to1 #(
  parameter int LSB_FIRST = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] in,
  output logic       out,
  output logic [2:0] sel,
  output logic       valid,
  output logic       busy,
`ifdef TDM_PARITY_EN
  output logic       parity_slot,
`endif
  output logic       done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
`ifdef TDM_PARITY_EN
  localparam logic [1:0] PAR  = 2'd2;
`endif
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [2:0] FIRST_SLOT = (LSB_FIRST != 0) ? 3'd0 : 3'd7;
  localparam logic [2:0] LAST_SLOT  = (LSB_FIRST != 0) ? 3'd7 : 3'd0;

  logic [1:0] state_q, state_d;
  logic [7:0] shadow_q, shadow_d;
  logic [2:0] slot_q, slot_d;
  logic [2:0] next_slot;
  logic       out_q, out_d;
  logic [2:0] sel_q, sel_d;
  logic       valid_q, valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
`ifdef TDM_PARITY_EN
  logic       parity_q, parity_d;
`endif

  // Outputs are computed for the state being entered, so every output is a flop.
  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    slot_d    = slot_q;
    out_d     = 1'b0;
    sel_d     = 3'd0;
    valid_d   = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
`ifdef TDM_PARITY_EN
    parity_d  = 1'b0;
`endif
    next_slot = (LSB_FIRST != 0) ? slot_q + 3'd1 : slot_q - 3'd1;

    case (state_q)
      IDLE: begin
        if (start) begin
          shadow_d = in;
          slot_d   = FIRST_SLOT;
          state_d  = SEND;
          valid_d  = 1'b1;
          busy_d   = 1'b1;
          sel_d    = FIRST_SLOT;
          out_d    = in[FIRST_SLOT];
        end
      end
      SEND: begin
        if (slot_q == LAST_SLOT) begin
`ifdef TDM_PARITY_EN
          state_d  = PAR;
          busy_d   = 1'b1;
          parity_d = 1'b1;
          out_d    = ^shadow_q;
`else
          state_d  = DONE;
          done_d   = 1'b1;
`endif
        end else begin
          slot_d  = next_slot;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          sel_d   = next_slot;
          out_d   = shadow_q[next_slot];
        end
      end
`ifdef TDM_PARITY_EN
      PAR: begin
        state_d = DONE;
        done_d  = 1'b1;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= 8'd0;
      slot_q   <= 3'd0;
      out_q    <= 1'b0;
      sel_q    <= 3'd0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef TDM_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      slot_q   <= slot_d;
      out_q    <= out_d;
      sel_q    <= sel_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef TDM_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign out   = out_q;
  assign sel   = sel_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign done  = done_q;
`ifdef TDM_PARITY_EN
  assign parity_slot = parity_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tdm_mux_8to1.sv
`default_nettype none
// tb_tdm_mux_8to1: directed bench driving an LSB-first and an MSB-first instance in parallel.
module tb_tdm_mux_8to1;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] din;

  logic       l_out, l_valid, l_busy, l_done;
  logic [2:0] l_sel;
  logic       m_out, m_valid, m_busy, m_done;
  logic [2:0] m_sel;
`ifdef TDM_PARITY_EN
  logic       l_par, m_par;
`endif

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] l_ch;
  logic [7:0] m_ch;

  always #5 clk = ~clk;

  tdm_mux_8to1 #(.LSB_FIRST(1)) dut_lsb (
    .clk(clk), .rst(rst), .start(start), .in(din),
    .out(l_out), .sel(l_sel), .valid(l_valid), .busy(l_busy),
`ifdef TDM_PARITY_EN
    .parity_slot(l_par),
`endif
    .done(l_done)
  );

  tdm_mux_8to1 #(.LSB_FIRST(0)) dut_msb (
    .clk(clk), .rst(rst), .start(start), .in(din),
    .out(m_out), .sel(m_sel), .valid(m_valid), .busy(m_busy),
`ifdef TDM_PARITY_EN
    .parity_slot(m_par),
`endif
    .done(m_done)
  );

  // Receiver side: 1-to-8 demultiplexers gated by valid.
  always @(negedge clk) begin
    if (l_valid) l_ch[l_sel] = l_out;
    if (m_valid) m_ch[m_sel] = m_out;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_check(input string tag);
    check({tag, "_l"}, {l_valid, l_busy, l_done, l_sel, l_out}, 32'd0);
    check({tag, "_m"}, {m_valid, m_busy, m_done, m_sel, m_out}, 32'd0);
`ifdef TDM_PARITY_EN
    check({tag, "_par"}, {l_par, m_par}, 32'd0);
`endif
  endtask

  // Entered on the first slot cycle; leaves on the idle cycle after done.
  task automatic frame(input logic [7:0] val, input bit clobber);
    for (int i = 0; i < 8; i++) begin
      check("l_slot", {l_valid, l_busy, l_done, l_sel, l_out}, {25'd0, 3'b110, 3'(i), val[i]});
      check("m_slot", {m_valid, m_busy, m_done, m_sel, m_out}, {25'd0, 3'b110, 3'(7 - i), val[7 - i]});
      if (clobber && i == 2) din = 8'h00;
      tick();
    end
`ifdef TDM_PARITY_EN
    check("l_parslot", {l_par, l_valid, l_busy, l_done, l_sel, l_out}, {26'd0, 4'b1010, 3'd0, ^val});
    check("m_parslot", {m_par, m_valid, m_busy, m_done, m_sel, m_out}, {26'd0, 4'b1010, 3'd0, ^val});
    tick();
    check("done_par", {l_par, m_par}, 32'd0);
`endif
    check("l_done", {l_valid, l_busy, l_done, l_sel, l_out}, {25'd0, 3'b001, 3'd0, 1'b0});
    check("m_done", {m_valid, m_busy, m_done, m_sel, m_out}, {25'd0, 3'b001, 3'd0, 1'b0});
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b0;
    start = 1'b0;
    din   = 8'h00;
    #2 rst = 1'b1;
    #1 idle_check("reset_async");
    tick();
    tick();
    idle_check("reset_held");
    rst = 1'b0;
    tick();
    idle_check("idle_after_reset");

    // Scenario 1/2: 1010_0110 -> LSB stream 0,1,1,0,0,1,0,1; F0 -> MSB stream 1,1,1,1,0,0,0,0
    din = 8'b1010_0110; start = 1'b1; tick(); start = 1'b0;
    frame(8'b1010_0110, 1'b0);
    idle_check("idle_s1");
    din = 8'hF0; start = 1'b1; tick(); start = 1'b0;
    frame(8'hF0, 1'b0);

    // Scenario 3: start held, input clobbered mid-frame, restart exactly 10 cycles later
    din = 8'hC3; start = 1'b1; tick();
    frame(8'hC3, 1'b1);
    idle_check("start_ignored_done");
    tick();
    start = 1'b0;
    frame(8'h00, 1'b0);

    // Scenario 4: asynchronous reset at slot 4
    din = 8'h5A; start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("pre_rst_l", {l_valid, l_sel}, {28'd0, 1'b1, 3'd4});
    check("pre_rst_m", {m_valid, m_sel}, {28'd0, 1'b1, 3'd3});
    #2 rst = 1'b1;
    #1 idle_check("rst_mid_frame");
    tick();
    rst = 1'b0;
    tick();
    idle_check("no_done_after_abort");
    din = 8'h3C; start = 1'b1; tick(); start = 1'b0;
    frame(8'h3C, 1'b0);

`ifdef TDM_PARITY_EN
    // Scenario 5: three ones -> parity bit 1
    din = 8'h07; start = 1'b1; tick(); start = 1'b0;
    frame(8'h07, 1'b0);
    check("par_idle", {l_par, m_par}, 32'd0);
`endif

    // Scenario 6: loopback through the demultiplexers for every input value
    for (int v = 0; v < 256; v++) begin
      din = 8'(v); start = 1'b1; tick(); start = 1'b0;
      frame(8'(v), 1'b0);
      check("loop_l", {24'd0, l_ch}, v);
      check("loop_m", {24'd0, m_ch}, v);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
